// File: rtl/hex_pkg.sv
// Shared constants and types for the eight-digit hex display controller.
package hex_pkg;

  localparam int NDIG = 8;

  // Active-low segment patterns: bit 0 = top segment ... bit 6 = middle.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_F     = 7'h0E;

  // Controller sequencing: accept a write, decode one digit per cycle, commit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/hex_blink_timer.sv
// Free-running blink timer: counts 0..BLINK_DIV-1 and toggles phase on each wrap.
module hex_blink_timer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  output logic phase
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Next count and phase: wrap to zero and flip phase at the last count.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/hexdriver.sv
// Hex nibble to active-low seven-segment pattern decoder (purely combinational).
module hexdriver (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup for 0-9, A, b, C, d, E, F.
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Eight-digit seven-segment controller. A write is decoded one digit per cycle
// through a single shared hexdriver into staging registers, then all digits are
// committed to the display registers in one cycle so no partial update shows.
//
// Handshake: a write is accepted on a rising edge where wr_valid & wr_ready are
// both high. wr_ready is only high in IDLE (and not in the first cycle after
// reset); while busy, wr_valid is ignored and the requester keeps holding it.
module hex_display_ctrl
  import hex_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_mask,
  input  logic        lz_suppress,
  input  logic [7:0]  blink_en,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [1:0]  dbg_state
);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  mask_q, mask_d;
  logic        lz_q, lz_d;
  logic [2:0]  idx_q, idx_d;
  logic        seen_q, seen_d;
  logic [6:0]  stage_q [NDIG];
  logic [6:0]  stage_d [NDIG];
  logic [6:0]  disp_q  [NDIG];
  logic [6:0]  disp_d  [NDIG];

  logic [3:0]  cur_nib;
  logic [6:0]  dec_seg;
  logic        phase;

  // The one shared decoder sees the nibble currently being scanned.
  assign cur_nib = data_q[{idx_q, 2'b00} +: 4];

  hexdriver u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  hex_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .phase (phase)
  );

  // Next-state logic for the write/scan/commit sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    data_d  = data_q;
    mask_d  = mask_q;
    lz_d    = lz_q;
    idx_d   = idx_q;
    seen_d  = seen_q;
    stage_d = stage_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (wr_valid && ready_q) begin
          data_d  = wr_data;
          mask_d  = wr_mask;
          lz_d    = lz_suppress;
          idx_d   = 3'd7;
          seen_d  = 1'b0;
          ready_d = 1'b0;
          state_d = SCAN;
        end else begin
          ready_d = 1'b1;
        end
      end
      SCAN: begin
        // Scan runs from the most significant digit down so seen_q knows
        // whether any visible non-zero digit lies above the current one.
        if (!mask_q[idx_q]) begin
          stage_d[idx_q] = SEG_BLANK;
        end else if (lz_q && (cur_nib == 4'h0) && !seen_q && (idx_q != 3'd0)) begin
          stage_d[idx_q] = SEG_BLANK;
        end else begin
          stage_d[idx_q] = dec_seg;
        end
        if (mask_q[idx_q] && (cur_nib != 4'h0)) begin
          seen_d = 1'b1;
        end
        if (idx_q == 3'd0) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      COMMIT: begin
        disp_d  = stage_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // Sequencer, shadow, staging and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      lz_q    <= 1'b0;
      idx_q   <= '0;
      seen_q  <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        stage_q[i] <= SEG_BLANK;
        disp_q[i]  <= SEG_BLANK;
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      lz_q    <= lz_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      stage_q <= stage_d;
      disp_q  <= disp_d;
    end
  end

  assign wr_ready  = ready_q;
  assign dbg_state = state_q;

  // Blink forces a digit blank during the high phase; blink_en is live.
  assign HEX0 = disp_q[0] | {7{blink_en[0] & phase}};
  assign HEX1 = disp_q[1] | {7{blink_en[1] & phase}};
  assign HEX2 = disp_q[2] | {7{blink_en[2] & phase}};
  assign HEX3 = disp_q[3] | {7{blink_en[3] & phase}};
  assign HEX4 = disp_q[4] | {7{blink_en[4] & phase}};
  assign HEX5 = disp_q[5] | {7{blink_en[5] & phase}};
  assign HEX6 = disp_q[6] | {7{blink_en[6] & phase}};
  assign HEX7 = disp_q[7] | {7{blink_en[7] & phase}};

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl with a short blink period.
module tb_hex_display_ctrl;
  import hex_pkg::*;

  localparam int BDIV = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic        lz_suppress = 1'b0;
  logic [7:0]  blink_en = '0;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [1:0]  dbg_state;

  hex_display_ctrl #(.BLINK_DIV(BDIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .lz_suppress (lz_suppress),
    .blink_en    (blink_en),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5),
    .HEX6        (HEX6),
    .HEX7        (HEX7),
    .dbg_state   (dbg_state)
  );

  logic [6:0] hex_w [8];
  assign hex_w[0] = HEX0;
  assign hex_w[1] = HEX1;
  assign hex_w[2] = HEX2;
  assign hex_w[3] = HEX3;
  assign hex_w[4] = HEX4;
  assign hex_w[5] = HEX5;
  assign hex_w[6] = HEX6;
  assign hex_w[7] = HEX7;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [6:0] seg_tbl [16];
  logic [6:0] cur_exp [8];

  // Rising edges since reset release: the blink phase is (edges / BDIV) odd.
  int edges = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  // Accepted writes, counted where valid and ready meet on a rising edge.
  int accepts = 0;
  always @(posedge clk) begin
    if (!rst && wr_valid && wr_ready) accepts <= accepts + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Digit n is visible if enabled and, under suppression, either it is digit 0
  // or some enabled digit at or above it holds a non-zero nibble.
  function automatic logic [6:0] model_digit(input logic [31:0] d, input logic [7:0] m,
                                             input logic lz, input int n);
    logic [3:0] nib;
    bit any_nz;
    nib = d[n*4 +: 4];
    if (!m[n]) return SEG_BLANK;
    if (lz && n != 0) begin
      any_nz = 0;
      for (int j = n; j < 8; j++)
        if (m[j] && d[j*4 +: 4] != 4'h0) any_nz = 1;
      if (!any_nz) return SEG_BLANK;
    end
    return seg_tbl[nib];
  endfunction

  function automatic logic [55:0] pack_hex();
    return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic logic [55:0] pack_exp();
    return {cur_exp[7], cur_exp[6], cur_exp[5], cur_exp[4],
            cur_exp[3], cur_exp[2], cur_exp[1], cur_exp[0]};
  endfunction

  task automatic check_display(input string tag);
    for (int n = 0; n < 8; n++)
      chk($sformatf("%s_hex%0d", tag, n), {57'd0, hex_w[n]}, {57'd0, cur_exp[n]});
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (wr_ready !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready_wait"}, {63'd0, wr_ready}, 64'd1);
  endtask

  // Driver: one write, with busy-period and commit-edge checks.
  task automatic do_write(input string tag, input logic [31:0] d, input logic [7:0] m,
                          input logic lz);
    wait_ready(tag);
    wr_valid    = 1'b1;
    wr_data     = d;
    wr_mask     = m;
    lz_suppress = lz;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("%s_busy_ready_%0d", tag, k), {63'd0, wr_ready}, 64'd0);
      chk($sformatf("%s_hold_%0d", tag, k), {8'd0, pack_hex()}, {8'd0, pack_exp()});
      @(negedge clk);
    end
    for (int n = 0; n < 8; n++) cur_exp[n] = model_digit(d, m, lz, n);
    check_display(tag);
    chk({tag, "_ready_after"}, {63'd0, wr_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  rm;
    logic        rl;
    int          a0;
    int          w;

    seg_tbl[0]  = 7'h40; seg_tbl[1]  = 7'h79; seg_tbl[2]  = 7'h24; seg_tbl[3]  = 7'h30;
    seg_tbl[4]  = 7'h19; seg_tbl[5]  = 7'h12; seg_tbl[6]  = 7'h02; seg_tbl[7]  = 7'h78;
    seg_tbl[8]  = 7'h00; seg_tbl[9]  = 7'h10; seg_tbl[10] = 7'h08; seg_tbl[11] = 7'h03;
    seg_tbl[12] = 7'h46; seg_tbl[13] = 7'h21; seg_tbl[14] = 7'h06; seg_tbl[15] = 7'h0E;
    for (int n = 0; n < 8; n++) cur_exp[n] = SEG_BLANK;

    // Asynchronous reset in the middle of a cycle
    #3 rst = 1'b1;
    #1;
    check_display("reset");
    chk("reset_ready", {63'd0, wr_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("release_ready_low", {63'd0, wr_ready}, 64'd0);
    @(negedge clk);
    chk("release_ready_high", {63'd0, wr_ready}, 64'd1);

    // Directed patterns
    do_write("w12345678", 32'h12345678, 8'hFF, 1'b0);
    chk("w12345678_hex0_const", {57'd0, HEX0}, {57'd0, SEG_8});
    chk("w12345678_hex7_const", {57'd0, HEX7}, {57'd0, SEG_1});
    do_write("wA0_lz", 32'h000000A0, 8'hFF, 1'b1);
    chk("wA0_hex1_const", {57'd0, HEX1}, {57'd0, SEG_A});
    chk("wA0_hex0_const", {57'd0, HEX0}, {57'd0, SEG_0});
    do_write("w0_lz", 32'h00000000, 8'hFF, 1'b1);
    chk("w0_hex0_const", {57'd0, HEX0}, {57'd0, SEG_0});
    chk("w0_hex7_const", {57'd0, HEX7}, {57'd0, SEG_BLANK});
    do_write("wF_mask0F", 32'hFFFFFFFF, 8'h0F, 1'b0);
    chk("wF_hex3_const", {57'd0, HEX3}, {57'd0, SEG_F});
    chk("wF_hex4_const", {57'd0, HEX4}, {57'd0, SEG_BLANK});
    do_write("w5_mask7F", 32'h00000005, 8'h7F, 1'b1);
    chk("w5_hex0_const", {57'd0, HEX0}, {57'd0, 7'h12});

    // Randomized writes, biased toward zero nibbles to exercise suppression
    for (int t = 0; t < 16; t++) begin
      for (int n = 0; n < 8; n++)
        rd[n*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rm = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      rl = 1'($urandom_range(0, 1));
      do_write($sformatf("rand%0d", t), rd, rm, rl);
    end

    // Blink on HEX0 with all digits showing '8'
    do_write("w8s", 32'h88888888, 8'hFF, 1'b0);
    blink_en = 8'h01;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("blink_hex0_%0d", k), {57'd0, HEX0},
          {57'd0, (((edges / BDIV) % 2) == 1) ? SEG_BLANK : SEG_8});
      chk($sformatf("blink_hex1_%0d", k), {57'd0, HEX1}, {57'd0, SEG_8});
      @(negedge clk);
    end
    w = 0;
    while (((edges / BDIV) % 2) != 1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("blink_phase_high_hex0", {57'd0, HEX0}, {57'd0, SEG_BLANK});
    blink_en = 8'h00;
    #1;
    chk("blink_clear_hex0", {57'd0, HEX0}, {57'd0, SEG_8});

    // Reset at E5 of a write aborts it and blanks everything
    wait_ready("abort");
    wr_valid = 1'b1;
    wr_data  = 32'hDEADBEEF;
    wr_mask  = 8'hFF;
    lz_suppress = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int n = 0; n < 8; n++) cur_exp[n] = SEG_BLANK;
    check_display("abort_reset");
    chk("abort_ready", {63'd0, wr_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", {63'd0, wr_ready}, 64'd1);
    repeat (12) @(negedge clk);
    check_display("abort_no_restore");
    do_write("w1_after", 32'h00000001, 8'hFF, 1'b0);

    // wr_valid held high: one accept per 10-cycle transaction
    wait_ready("held");
    a0 = accepts;
    wr_valid = 1'b1;
    wr_data  = 32'h0000ABCD;
    wr_mask  = 8'hFF;
    lz_suppress = 1'b1;
    repeat (30) @(negedge clk);
    wr_valid = 1'b0;
    chk("held_accepts", 64'(accepts - a0), 64'd3);
    for (int n = 0; n < 8; n++) cur_exp[n] = model_digit(32'h0000ABCD, 8'hFF, 1'b1, n);
    check_display("held");
    chk("held_ready", {63'd0, wr_ready}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Eight-digit seven-segment display controller for the board's HEX0..HEX7 outputs.
- Accepts a 32-bit value over a valid/ready write port and time-shares one hexdriver decoder across all eight digits, one digit per cycle.
- Commits all digits in a single cycle, so a partial update is never visible.
- Adds per-digit masking, leading-zero suppression and per-digit blink.

Parameters:
- NDIG, 8, number of digits; fixed at 8 in this revision.
- BLINK_DIV, 25000000, clk cycles per blink half-period.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  controller idle; write accepted when wr_valid & wr_ready at a rising edge
- wr_data  in  32  value; nibble n drives HEXn
- wr_mask  in  8  digit enable; bit n = 0 forces HEXn blank
- lz_suppress  in  1  enable leading-zero suppression, sampled with the write
- blink_en  in  8  live per-digit blink enable, not latched
- HEX0..HEX7  out  7 each  active-low segment patterns, bit 0 = top segment ... bit 6 = middle

Behaviour:
- Segments are active low. Blank is 7'h7F.
- Reset (async, rst=1):
  - state = IDLE.
  - Display registers and staging registers = 7'h7F, so every HEXn = 7'h7F.
  - Blink counter = 0, blink phase = 0.
  - wr_ready = 0 while rst is high; wr_ready = (state==IDLE) after rst is released.
- FSM states IDLE, SCAN, COMMIT:
  - IDLE: wr_ready=1. On handshake, latch wr_data, wr_mask and lz_suppress into shadow registers; set idx=7, seen_nz=0; go to SCAN.
  - SCAN: wr_ready=0. Each cycle, feed nibble[idx] to the shared hexdriver and write staging[idx]:
    - 7'h7F if mask[idx]=0;
    - else 7'h7F if lz=1, nibble==0, seen_nz=0 and idx!=0;
    - else the decoder output.
    - Set seen_nz if nibble!=0 and mask[idx]=1. Masked digits never set seen_nz.
    - When idx==0, go to COMMIT; otherwise decrement idx.
  - COMMIT: copy all staging registers into the display registers in one cycle; go to IDLE.
- Latency: handshake at edge E0. SCAN occupies E1..E8, COMMIT at E9. New HEX values are visible after E9, all eight changing simultaneously. wr_ready returns high after E9.
- Digit 0 is never zero-suppressed. A value of 0 with lz=1 shows "0" on HEX0 and blanks the rest.
- Blink:
  - The free-running counter counts 0..BLINK_DIV-1; on wrap it toggles phase.
  - It runs in all states and is unaffected by writes.
  - HEXn = display[n] | {7{blink_en[n] & phase}}, a combinational OR from registers.
- wr_valid while busy: ignored, no queuing. The requester holds wr_valid until wr_ready.
- wr_valid held high continuously: one write per 10 cycles, each sampled at the IDLE edge.
- Reset mid-SCAN or mid-COMMIT: transaction aborted, all outputs blank, staged data discarded.
- No X on outputs at any time after reset assertion.

Decomposition:
- Package hex_pkg holds:
  - NDIG;
  - SEG_BLANK = 7'h7F;
  - state enum {IDLE, SCAN, COMMIT};
  - segment constants for tests: SEG_0=7'h40, SEG_1=7'h79, SEG_8=7'h00, SEG_A=7'h08, SEG_F=7'h0E.
- Reuse exactly one hexdriver instance as the shared decoder.
- Natural sub-module: hex_blink_timer (counter plus phase flop, parameter BLINK_DIV, outputs phase).

Test Plan:
- Reset: assert rst mid-cycle (asynchronous) -> all HEXn=7'h7F immediately and wr_ready=0; release -> wr_ready=1 the next cycle.
- Write 32'h12345678, mask 8'hFF, lz=0 at E0:
  - wr_ready=0 for E1..E9;
  - after E9, HEX0=7'h00 ('8') and HEX7=7'h79 ('1');
  - all eight digits change on the same edge, unchanged before it.
- Write 32'h000000A0, lz=1 -> HEX7..HEX2=7'h7F, HEX1=7'h08, HEX0=7'h40. Then write 32'h0, lz=1 -> HEX0=7'h40, the rest blank.
- Write 32'hFFFFFFFF, mask 8'h0F -> HEX7..HEX4=7'h7F, HEX3..HEX0=7'h0E. Also: mask 8'h7F with 32'h00000005, lz=1 -> HEX7 blank, HEX0=digit 5, HEX6..1 blank.
- BLINK_DIV=4, blink_en=8'h01, display '8':
  - HEX0 alternates 7'h00 / 7'h7F every 4 cycles; HEX1..7 are steady.
  - Clearing blink_en returns HEX0 to 7'h00 within one cycle.
- Robustness:
  - Assert rst at E5 of a write -> outputs blank, old value not restored.
  - After release, write 32'h1 -> shown 10 cycles later.
  - wr_valid held high through the busy period -> exactly one accept per 10-cycle transaction.
